// File: rtl/pi_axis_scheduler.sv
// Shares one PI velocity datapath across NUM_AXES axes. Each control tick starts a sweep
// over the enabled axes and latches every axis response into its own ctrl_out slice.
module pi_axis_scheduler #(
    parameter int NUM_AXES    = 4,
    parameter int AXIS_W      = 2,
    parameter int TICK_DIV    = 5000,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NUM_AXES-1:0]      axis_en,
    output logic                     req_valid,
    output logic [AXIS_W-1:0]        req_axis,
    input  logic                     req_ready,
    input  logic                     rsp_valid,
    input  logic [AXIS_W-1:0]        rsp_axis,
    input  logic signed [15:0]       rsp_data,
    output logic [16*NUM_AXES-1:0]   ctrl_out,
    output logic                     ctrl_update,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int WAIT_W = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_reg, state_next;
    logic [NUM_AXES-1:0]   pending_reg, pending_next;
    logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [TICK_W-1:0]     tick_cnt_reg;
    logic                  overrun_reg;
    logic                  timeout_err_reg;
    logic [1:0]            rst_sync_reg;
    logic                  rst_n_int;
    logic                  tick;
    logic [NUM_AXES-1:0]   cur_bit;
    logic [AXIS_W-1:0]     cur_axis;
    logic                  accept;
    logic                  expire;
    logic                  slot_end;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_reg[1];

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tick_cnt_reg <= '0;
        end else if (!enable) begin
            tick_cnt_reg <= '0;
        end else if (tick_cnt_reg == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    assign tick = enable && (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

    // The current axis is the lowest pending bit; it stays put until its slot ends.
    assign cur_bit = pending_reg & (~pending_reg + 1'b1);

    always_comb begin
        cur_axis = '0;
        for (int i = NUM_AXES - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                cur_axis = AXIS_W'(i);
            end
        end
    end

    assign accept   = (state_reg == WAIT) && rsp_valid && (rsp_axis == cur_axis);
    assign expire   = (state_reg == WAIT) && !accept && (wait_cnt_reg == WAIT_W'(RSP_TIMEOUT - 1));
    assign slot_end = accept || expire;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (tick) begin
                    pending_next = axis_en;
                    if (axis_en != '0) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    wait_cnt_next = '0;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (slot_end) begin
                    pending_next = pending_reg & ~cur_bit;
                    state_next   = (pending_next != '0) ? ISSUE : DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A timed-out axis is forced to zero output so its motor coasts to a safe stop.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXES; gi++) begin : g_slice
            logic [15:0] slice_reg;

            always_ff @(posedge clk or negedge rst_n_int) begin
                if (!rst_n_int) begin
                    slice_reg <= '0;
                end else if (slot_end && cur_bit[gi]) begin
                    slice_reg <= accept ? rsp_data : 16'sd0;
                end
            end

            assign ctrl_out[16*gi +: 16] = slice_reg;
        end
    endgenerate

    // Setting an error flag takes priority over clearing it in the same cycle.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (tick && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end else if (clr_err) begin
                overrun_reg <= 1'b0;
            end
            if (expire) begin
                timeout_err_reg <= 1'b1;
            end else if (clr_err) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    assign req_valid   = (state_reg == ISSUE);
    assign req_axis    = cur_axis;
    assign ctrl_update = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign overrun     = overrun_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_pi_axis_scheduler.sv
// Directed bench for pi_axis_scheduler: the bench plays the PI datapath with hand-picked
// latencies and compares outputs against hand-computed values.
module tb_pi_axis_scheduler;

    localparam int NUM_AXES    = 4;
    localparam int AXIS_W      = 2;
    localparam int TICK_DIV    = 100;
    localparam int RSP_TIMEOUT = 64;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   enable = 1'b0;
    logic [NUM_AXES-1:0]    axis_en = '0;
    logic                   req_valid;
    logic [AXIS_W-1:0]      req_axis;
    logic                   req_ready = 1'b0;
    logic                   rsp_valid = 1'b0;
    logic [AXIS_W-1:0]      rsp_axis = '0;
    logic signed [15:0]     rsp_data = '0;
    logic [16*NUM_AXES-1:0] ctrl_out;
    logic                   ctrl_update;
    logic                   busy;
    logic                   overrun;
    logic                   timeout_err;
    logic                   clr_err = 1'b0;

    int n_checks = 0;
    int n_bad    = 0;

    pi_axis_scheduler #(
        .NUM_AXES   (NUM_AXES),
        .AXIS_W     (AXIS_W),
        .TICK_DIV   (TICK_DIV),
        .RSP_TIMEOUT(RSP_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .axis_en    (axis_en),
        .req_valid  (req_valid),
        .req_axis   (req_axis),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_axis   (rsp_axis),
        .rsp_data   (rsp_data),
        .ctrl_out   (ctrl_out),
        .ctrl_update(ctrl_update),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int limit, output int n);
        n = 0;
        while (!req_valid && n < limit) begin
            step();
            n++;
        end
        check_val("req_valid_seen", 64'(req_valid), 64'd1);
    endtask

    task automatic handshake(input int ax, input int hold);
        int unstable;
        unstable = 0;
        check_val("req_axis", 64'(req_axis), 64'(ax));
        for (int i = 0; i < hold; i++) begin
            req_ready = 1'b0;
            step();
            if (req_valid !== 1'b1 || req_axis !== AXIS_W'(ax)) unstable++;
        end
        check_val("req_hold_stable", 64'(unstable), 64'd0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check_val("req_dropped_after_hs", 64'(req_valid), 64'd0);
    endtask

    task automatic respond(input int ax, input logic [15:0] d, input int lat);
        repeat (lat - 1) step();
        rsp_valid = 1'b1;
        rsp_axis  = AXIS_W'(ax);
        rsp_data  = d;
        step();
        rsp_valid = 1'b0;
    endtask

    task automatic serve(input int ax, input logic [15:0] d, input int hold, input int lat);
        int n;
        wait_req(300, n);
        handshake(ax, hold);
        respond(ax, d, lat);
    endtask

    initial begin
        int n;
        int cnt;

        // Reset state
        #2;
        check_val("rst_req_valid", 64'(req_valid), 64'd0);
        check_val("rst_ctrl_out", ctrl_out, 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_ctrl_update", 64'(ctrl_update), 64'd0);
        check_val("rst_flags", 64'({overrun, timeout_err}), 64'd0);
        step();
        reset_n = 1'b1;
        enable  = 1'b1;

        // 1: axes 0,1,3 in order, axis 2 keeps its old value
        axis_en = 4'b1011;
        serve(0, 16'h0064, 0, 3);
        serve(1, 16'hFF38, 0, 3);
        serve(3, 16'h0FA0, 0, 3);
        check_val("t1_ctrl_update_pulse", 64'(ctrl_update), 64'd1);
        step();
        check_val("t1_ctrl_update_end", 64'(ctrl_update), 64'd0);
        check_val("t1_idle", 64'(busy), 64'd0);
        check_val("t1_ctrl_out", ctrl_out, 64'h0FA0_0000_FF38_0064);

        // 2: ready held low for 10 cycles, handshake on the 11th
        axis_en = 4'b0001;
        serve(0, 16'h022B, 10, 2);
        step();
        check_val("t2_slice0", 64'(ctrl_out[15:0]), 64'h022B);
        check_val("t2_no_timeout", 64'(timeout_err), 64'd0);

        // 3: axis 1 never answers -> timeout after 64 WAIT cycles, then axis 2
        axis_en = 4'b0110;
        wait_req(300, n);
        handshake(1, 0);
        n = 0;
        while (!req_valid && n < 200) begin
            step();
            n++;
        end
        check_val("t3_timeout_cycles", 64'(n), 64'd64);
        check_val("t3_slice1_safe", 64'(ctrl_out[31:16]), 64'd0);
        check_val("t3_timeout_err", 64'(timeout_err), 64'd1);
        handshake(2, 0);
        respond(2, 16'h004D, 2);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_val("t3_clr_timeout", 64'(timeout_err), 64'd0);

        // 4: stray response for axis 2 while waiting on axis 0 is ignored
        axis_en = 4'b0101;
        wait_req(300, n);
        handshake(0, 0);
        step();
        rsp_valid = 1'b1;
        rsp_axis  = 2'd2;
        rsp_data  = 16'h04D2;
        step();
        rsp_valid = 1'b0;
        check_val("t4_still_waiting", 64'({busy, req_valid}), 64'b10);
        check_val("t4_slice2_unchanged", 64'(ctrl_out[47:32]), 64'h004D);
        respond(0, 16'h002A, 2);
        check_val("t4_next_axis", 64'({req_valid, req_axis}), 64'b110);
        handshake(2, 0);
        respond(2, 16'hFFF9, 2);
        step();
        check_val("t4_ctrl_out", ctrl_out, 64'h0FA0_FFF9_0000_002A);

        // 5: sweep still busy at the next tick; clr_err in that cycle loses to the set
        axis_en = 4'b0001;
        wait_req(300, n);
        req_ready = 1'b0;
        repeat (TICK_DIV - 1) step();
        check_val("t5_overrun_before", 64'(overrun), 64'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_val("t5_overrun_set", 64'(overrun), 64'd1);
        check_val("t5_req_unchanged", 64'({req_valid, req_axis}), 64'b100);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        repeat (5) step();

        // 6: reset mid-WAIT clears everything at once; first request a full period later
        reset_n = 1'b0;
        #1;
        check_val("t6_busy", 64'(busy), 64'd0);
        check_val("t6_req_valid", 64'(req_valid), 64'd0);
        check_val("t6_ctrl_out", ctrl_out, 64'd0);
        check_val("t6_flags", 64'({overrun, timeout_err, ctrl_update}), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        wait_req(300, n);
        check_val("t6_first_req_gap", 64'((n >= TICK_DIV) && (n <= TICK_DIV + 3)), 64'd1);
        handshake(0, 0);
        respond(0, 16'h1111, 3);
        check_val("t6_ctrl_update", 64'(ctrl_update), 64'd1);
        step();
        check_val("t6_slice0", 64'(ctrl_out[15:0]), 64'h1111);

        // 7: tick with no axis enabled -> no sweep, no ctrl_update
        axis_en = 4'b0000;
        cnt = 0;
        repeat (150) begin
            step();
            if (busy || ctrl_update) cnt++;
        end
        check_val("t7_no_sweep", 64'(cnt), 64'd0);

        // 8: enable low -> no tick
        enable  = 1'b0;
        axis_en = 4'b1111;
        cnt = 0;
        repeat (250) begin
            step();
            if (busy || req_valid) cnt++;
        end
        check_val("t8_disabled", 64'(cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
